nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller: steps a phase increment through a sweep and streams
// accumulated phase over a req/ack handshake. Optional dither enabled by NCO_SWEEP_DITHER_EN.
module nco_sweep_ctrl #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               repeat_en,
    input  logic [PHASE_W-1:0] freq_start,
    input  logic [PHASE_W-1:0] freq_step,
    input  logic [CNT_W-1:0]   step_count,
    input  logic [CNT_W-1:0]   dwell,
    output logic [PHASE_W-1:0] angle_dat,
    output logic               angle_req,
    input  logic               angle_ack,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] cur_freq
);

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND, DONE} state_t;

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q, cur_freq_q, fstart_q, fstep_q, angle_dat_q;
    logic [CNT_W-1:0]   step_idx_q, dwell_cnt_q, scount_q, dwell_q;
    logic               repeat_q, angle_req_q, busy_q, done_q;

    logic               xfer, dwell_wrap, last_xfer, stop_now;
    logic [PHASE_W-1:0] phase_d, cur_freq_d, dith_q, dith_d;
    logic [CNT_W-1:0]   step_idx_d, dwell_cnt_d;

`ifdef NCO_SWEEP_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
`endif

    always_comb begin
        xfer        = angle_req_q & angle_ack;
        dwell_wrap  = (dwell_cnt_q == dwell_q);
        last_xfer   = dwell_wrap && (step_idx_q == scount_q);
        stop_now    = (state_q == STOP_PEND) || stop;
        phase_d     = phase_q + cur_freq_q;
        dwell_cnt_d = dwell_wrap ? '0 : dwell_cnt_q + CNT_W'(1);
        step_idx_d  = dwell_wrap ? step_idx_q + CNT_W'(1) : step_idx_q;
        cur_freq_d  = dwell_wrap ? cur_freq_q + fstep_q : cur_freq_q;
`ifdef NCO_SWEEP_DITHER_EN
        // Taps 16,14,13,11 -> bits 15,13,12,10; dither never feeds the accumulator
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = xfer ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
        dith_q  = PHASE_W'(lfsr_q[7:0]);
        dith_d  = PHASE_W'(lfsr_d[7:0]);
`else
        dith_q = '0;
        dith_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cur_freq_q  <= '0;
            fstart_q    <= '0;
            fstep_q     <= '0;
            angle_dat_q <= '0;
            step_idx_q  <= '0;
            dwell_cnt_q <= '0;
            scount_q    <= '0;
            dwell_q     <= '0;
            repeat_q    <= 1'b0;
            angle_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef NCO_SWEEP_DITHER_EN
            lfsr_q      <= 16'hACE1;
`endif
        end else begin
`ifdef NCO_SWEEP_DITHER_EN
            lfsr_q <= lfsr_d;
`endif
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fstart_q    <= freq_start;
                        fstep_q     <= freq_step;
                        scount_q    <= step_count;
                        dwell_q     <= dwell;
                        repeat_q    <= repeat_en;
                        phase_q     <= '0;
                        step_idx_q  <= '0;
                        dwell_cnt_q <= '0;
                        cur_freq_q  <= freq_start;
                        angle_dat_q <= dith_q;
                        angle_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN, STOP_PEND: begin
                    if (xfer) begin
                        // Terminating transfers freeze the datapath so IDLE shows the last sample
                        if (stop_now || (last_xfer && !repeat_q)) begin
                            angle_req_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else if (last_xfer) begin
                            phase_q     <= '0;
                            step_idx_q  <= '0;
                            dwell_cnt_q <= '0;
                            cur_freq_q  <= fstart_q;
                            angle_dat_q <= dith_d;
                        end else begin
                            phase_q     <= phase_d;
                            step_idx_q  <= step_idx_d;
                            dwell_cnt_q <= dwell_cnt_d;
                            cur_freq_q  <= cur_freq_d;
                            angle_dat_q <= phase_d + dith_d;
                        end
                    end else if (state_q == RUN && stop) begin
                        state_q <= STOP_PEND;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign angle_dat = angle_dat_q;
    assign angle_req = angle_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_freq  = cur_freq_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with a sweep-level reference model of the sample stream.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, repeat_en = 1'b0, angle_ack = 1'b0;
    logic [31:0] freq_start = '0, freq_step = '0;
    logic [15:0] step_count = '0, dwell = '0;
    logic [31:0] angle_dat, cur_freq;
    logic        angle_req, busy, done;

    nco_sweep_ctrl #(.PHASE_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .repeat_en(repeat_en),
        .freq_start(freq_start), .freq_step(freq_step), .step_count(step_count),
        .dwell(dwell), .angle_dat(angle_dat), .angle_req(angle_req),
        .angle_ack(angle_ack), .busy(busy), .done(done), .cur_freq(cur_freq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] exp_ang[$], exp_frq[$];
    bit          mdl_on = 0, mdl_rep = 0;
    logic [31:0] m_fs, m_fstep;
    logic [15:0] m_sc, m_dw;
    int          xfers = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One whole sweep: every step s uses fs + s*fstep for dwell+1 samples.
    function automatic void build(input logic [31:0] fs, input logic [31:0] fstep,
                                  input logic [15:0] sc, input logic [15:0] dw);
        logic [31:0] ph = '0;
        logic [31:0] f  = fs;
        for (int s = 0; s <= int'(sc); s++) begin
            for (int d = 0; d <= int'(dw); d++) begin
                exp_ang.push_back(ph);
                exp_frq.push_back(f);
                ph = ph + f;
            end
            f = f + fstep;
        end
    endfunction

    always @(negedge clk) begin
        if (mdl_on && angle_req === 1'b1) begin
            if (exp_ang.size() == 0 && mdl_rep) build(m_fs, m_fstep, m_sc, m_dw);
            if (exp_ang.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_sample: got angle_dat 0x%0h expected no request", angle_dat);
            end else begin
                chk("angle_dat", angle_dat, exp_ang[0]);
                chk("cur_freq", cur_freq, exp_frq[0]);
                if (angle_ack === 1'b1) begin
                    void'(exp_ang.pop_front());
                    void'(exp_frq.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fstep,
                               input logic [15:0] sc, input logic [15:0] dw, input bit rep);
        exp_ang.delete();
        exp_frq.delete();
        build(fs, fstep, sc, dw);
        m_fs = fs; m_fstep = fstep; m_sc = sc; m_dw = dw; mdl_rep = rep;
        xfers = 0;
        mdl_on = 1;
        freq_start = fs; freq_step = fstep; step_count = sc; dwell = dw; repeat_en = rep;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        freq_start = 32'hDEAD0000; freq_step = 32'h0BAD0000;
        step_count = 16'h7777; dwell = 16'h5555; repeat_en = ~rep;
    endtask

    task automatic end_sweep();
        mdl_on = 0;
        exp_ang.delete();
        exp_frq.delete();
    endtask

    // ack_mode: 0 always 1, 1 toggles 1,0,1,0, 2 low only on the stop cycle
    task automatic drive(input int ack_mode, input int stop_at, input int restart_at,
                         input int max_cyc, output int done_at, output int done_cnt,
                         output int busy_low);
        done_at = -1; done_cnt = 0; busy_low = 0;
        for (int i = 0; i < max_cyc; i++) begin
            case (ack_mode)
                0:       angle_ack = 1'b1;
                1:       angle_ack = (i % 2 == 0);
                default: angle_ack = (i != stop_at);
            endcase
            stop  = (i == stop_at);
            start = (i == restart_at);
            if (start) freq_start = 32'd999;
            @(negedge clk);
            if (ack_mode == 2 && i == stop_at + 1) chk("stop_pend_req", angle_req, 1);
            if (done === 1'b1) begin
                if (done_at < 0) begin
                    done_at = i;
                    chk("req_in_done", angle_req, 0);
                    chk("busy_in_done", busy, 1);
                end
                done_cnt++;
            end else if (done_at < 0 && busy !== 1'b1) begin
                busy_low++;
            end
            @(posedge clk); #1;
        end
        angle_ack = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_req"}, angle_req, 0);
    endtask

    initial begin
        int da, dc, bl, nd;
        logic [31:0] pin1[6] = '{32'd0, 32'd100, 32'd200, 32'd310, 32'd420, 32'd540};
        logic [31:0] pin3[4] = '{32'h0, 32'hC0000000, 32'h80000000, 32'h40000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", angle_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dat", angle_dat, 0);
        chk("rst_freq", cur_freq, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        build(32'd100, 32'd10, 16'd2, 16'd1);
        chk("pin_basic_len", exp_ang.size(), 6);
        for (int k = 0; k < 6; k++) chk("pin_basic", exp_ang[k], pin1[k]);
        chk("pin_basic_freq", exp_frq[5], 32'd120);
        end_sweep();
        build(32'hC0000000, 32'd7, 16'd0, 16'd3);
        for (int k = 0; k < 4; k++) chk("pin_wrap", exp_ang[k], pin3[k]);
        end_sweep();

        // basic sweep
        start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 0);
        drive(0, -1, -1, 10, da, dc, bl);
        chk("basic_done_at", da, 6);
        chk("basic_done_cnt", dc, 1);
        chk("basic_xfers", xfers, 6);
        chk("basic_left", exp_ang.size(), 0);
        chk("basic_busy", bl, 0);
        end_sweep();
        idle_check("basic_idle");

        // backpressure
        start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 0);
        drive(1, -1, -1, 16, da, dc, bl);
        chk("bp_done_at", da, 11);
        chk("bp_done_cnt", dc, 1);
        chk("bp_xfers", xfers, 6);
        end_sweep();

        // phase wrap
        start_sweep(32'hC0000000, 32'd7, 16'd0, 16'd3, 0);
        drive(0, -1, -1, 8, da, dc, bl);
        chk("wrap_done_at", da, 4);
        chk("wrap_xfers", xfers, 4);
        end_sweep();

        // repeat until stop (stop coincides with a transfer)
        start_sweep(32'd5, 32'd3, 16'd0, 16'd1, 1);
        drive(0, 9, -1, 14, da, dc, bl);
        chk("rep_done_at", da, 10);
        chk("rep_done_cnt", dc, 1);
        chk("rep_busy", bl, 0);
        chk("rep_xfers", xfers, 10);
        end_sweep();
        idle_check("rep_idle");

        // stop while ack low -> STOP_PEND
        start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 0);
        drive(2, 2, -1, 8, da, dc, bl);
        chk("pend_done_at", da, 4);
        chk("pend_done_cnt", dc, 1);
        chk("pend_xfers", xfers, 3);
        end_sweep();
        idle_check("pend_idle");

        // stop on the normal last transfer
        start_sweep(32'd100, 32'd10, 16'd0, 16'd1, 0);
        drive(0, 1, -1, 6, da, dc, bl);
        chk("coinc_done_at", da, 2);
        chk("coinc_done_cnt", dc, 1);
        end_sweep();

        // start while busy
        start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 0);
        drive(0, -1, 2, 10, da, dc, bl);
        chk("rebusy_done_at", da, 6);
        chk("rebusy_xfers", xfers, 6);
        end_sweep();

        // reset mid-sweep
        start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 0);
        angle_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        end_sweep();
        reset = 1'b1;
        #1;
        chk("mrst_req", angle_req, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_dat", angle_dat, 0);
        chk("mrst_freq", cur_freq, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        angle_ack = 1'b0;
        nd = 0;
        repeat (4) begin @(negedge clk); if (done === 1'b1) nd++; end
        chk("mrst_no_done", nd, 0);

        // fresh sweep after reset
        start_sweep(32'd7, 32'd1, 16'd1, 16'd0, 0);
        drive(0, -1, -1, 5, da, dc, bl);
        chk("post_done_at", da, 2);
        chk("post_xfers", xfers, 2);
        end_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
